// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg : shared types and widths for the MM:SS countdown timer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package timer_pkg;

  localparam int MIN_W       = 7;
  localparam int SEC_W       = 6;
  localparam int ALARM_CNT_W = 4;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/timer_alarm_hold.sv
// ---------------------------------------------------------------------------
// timer_alarm_hold : counts 1 s ticks while the alarm sounds, flags timeout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module timer_alarm_hold
  import timer_pkg::*;
#(
  parameter int ALARM_SECS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_expire
);

  localparam logic [ALARM_CNT_W-1:0] c_last = ALARM_CNT_W'(ALARM_SECS - 1);

  logic [ALARM_CNT_W-1:0] r_cnt;

  // Expiry is flagged on the tick that would bring the count up to ALARM_SECS.
  assign o_expire = i_en && i_tick && (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && i_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer : settable MM:SS countdown with pause/resume and timed alarm
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module countdown_timer
  import timer_pkg::*;
#(
  parameter int MAX_MIN    = 99,
  parameter int ALARM_SECS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1s,
  input  logic             btn_start,
  input  logic             btn_set,
  input  logic             btn_inc_min,
  input  logic             btn_inc_sec,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             running,
  output logic             alarm
);

  localparam logic [MIN_W-1:0] c_max_min = MIN_W'(MAX_MIN);

  state_t           r_state, w_state_nxt;
  logic [MIN_W-1:0] r_min, w_min_nxt, w_dec_min;
  logic [SEC_W-1:0] r_sec, w_sec_nxt, w_dec_sec;
  logic             r_running, r_alarm, w_alarm_nxt;
  logic             w_time_zero, w_dec_zero, w_ack, w_expire;

  assign w_time_zero = (r_min == '0) && (r_sec == '0);
  assign w_ack       = (r_state == DONE) && (btn_start || btn_set);

  // One-second decrement with borrow; holds at 00:00 so RUN can never underflow.
  always_comb begin
    w_dec_min = r_min;
    w_dec_sec = r_sec;
    if (r_sec != '0) begin
      w_dec_sec = r_sec - 1'b1;
    end else if (r_min != '0) begin
      w_dec_min = r_min - 1'b1;
      w_dec_sec = SEC_MAX;
    end
  end

  assign w_dec_zero = (w_dec_min == '0) && (w_dec_sec == '0);

  timer_alarm_hold #(
    .ALARM_SECS (ALARM_SECS)
  ) u_alarm_hold (
    .clk      (clk),
    .rst      (reset),
    .i_en     (r_state == DONE),
    .i_clr    ((r_state != DONE) || w_ack),
    .i_tick   (tick_1s),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_alarm_nxt = r_alarm;
    case (r_state)
      IDLE: begin
        if (btn_start && !w_time_zero) begin
          w_state_nxt = RUN;
        end else if (btn_set) begin
          w_state_nxt = SET;
        end
      end
      SET: begin
        if (btn_set) begin
          w_state_nxt = IDLE;
        end else begin
          if (btn_inc_sec) begin
            w_sec_nxt = (r_sec == SEC_MAX) ? '0 : r_sec + 1'b1;
          end
          if (btn_inc_min) begin
            w_min_nxt = (r_min == c_max_min) ? '0 : r_min + 1'b1;
          end
        end
      end
      RUN: begin
        if (tick_1s) begin
          w_min_nxt = w_dec_min;
          w_sec_nxt = w_dec_sec;
        end
        // Reaching 00:00 takes precedence over a same-cycle pause request.
        if (w_time_zero || (tick_1s && w_dec_zero)) begin
          w_state_nxt = DONE;
          w_alarm_nxt = 1'b1;
        end else if (btn_start) begin
          w_state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (btn_start) begin
          w_state_nxt = RUN;
        end else if (btn_set) begin
          w_state_nxt = SET;
        end
      end
      DONE: begin
        if (w_ack || w_expire) begin
          w_state_nxt = IDLE;
          w_alarm_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_alarm_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_min     <= '0;
      r_sec     <= '0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_min     <= w_min_nxt;
      r_sec     <= w_sec_nxt;
      r_running <= (w_state_nxt == RUN);
      r_alarm   <= w_alarm_nxt;
    end
  end

  assign minutes = r_min;
  assign seconds = r_sec;
  assign running = r_running;
  assign alarm   = r_alarm;

endmodule

`default_nettype wire
